mc_core_param: RTL

//  Parametrised multicycle accumulator-style CPU core: next generation of the 8-bit w-series core.

---
 rtl/mc_core_param.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_core_param.sv
// Parametrised multicycle accumulator-style core: IF/ID/IMM/EX/WB sequencer around an
// NREG x N register file, r0-indirect memory operand, stall freeze and retired counter.
module mc_core_param #(
  parameter int N          = 8,
  parameter int NREG       = 4,
  parameter int RW         = 2,
  parameter int SIGNED_CMP = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  output logic [N-1:0]     mem_rd_addr1,
  input  logic [N-1:0]     mem_rd_data1,
  output logic [N-1:0]     mem_rd_addr2,
  input  logic [N-1:0]     mem_rd_data2,
  output logic [N-1:0]     mem_wr_addr,
  output logic [N-1:0]     mem_wr_data,
  output logic             mem_wr_en,
  output logic [CNT_W-1:0] retired
);

  generate
    if (N < 4 + 2 * RW || NREG != (1 << RW)) begin : g_bad_params
      $error("mc_core_param: need NREG == 2**RW and N >= 4+2*RW");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_IMM = 3'd2,
    S_EX  = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SUBI = 3'd3;
  localparam logic [2:0] OP_MOV  = 3'd4;
  localparam logic [2:0] OP_MOVI = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_BLT  = 3'd7;

  state_t           state_reg, state_next;
  logic [N-1:0]     pc_reg, pc_next;
  logic [N-1:0]     ir_reg, ir_next;
  logic [N-1:0]     op1_reg, op1_next;
  logic [N-1:0]     op0_reg, op0_next;
  logic [N-1:0]     result_reg, result_next;
  logic             wr_en_reg, wr_en_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic [N-1:0]     regs_reg [NREG];

  logic [2:0]       op;
  logic [RW-1:0]    reg1;
  logic [RW-1:0]    reg0;
  logic             dst;
  logic             is_mem_op;
  logic             needs_imm;
  logic             mem_src;
  logic [N-1:0]     cmp_a;
  logic [N-1:0]     cmp_b;
  logic             br_eq;
  logic             br_lt;
  logic             br_taken;
  logic [RW-1:0]    wb_sel;
  logic             wb_active;
  logic [NREG-1:0]  reg_we;

  assign op   = ir_reg[N-1 -: 3];
  assign reg1 = ir_reg[N-4 -: RW];
  assign reg0 = ir_reg[N-4-RW -: RW];
  assign dst  = ir_reg[0];

  assign is_mem_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MOV);
  assign needs_imm = !is_mem_op;
  // r0 field selects the memory word addressed by r0 instead of a register
  assign mem_src   = is_mem_op && (reg0 == '0);

  // Branches compare live register contents; op0 already holds the offset by EX
  assign cmp_a = regs_reg[reg1];
  assign cmp_b = regs_reg[reg0];
  assign br_eq = (cmp_a == cmp_b);

  generate
    if (SIGNED_CMP != 0) begin : g_signed_cmp
      assign br_lt = ($signed(cmp_a) < $signed(cmp_b));
    end else begin : g_unsigned_cmp
      assign br_lt = (cmp_a < cmp_b);
    end
  endgenerate

  assign br_taken = (op == OP_BEQ) ? br_eq : br_lt;

  // A WB cycle with the memory strobe up writes memory instead of the register file
  assign wb_sel    = dst ? reg1 : reg0;
  assign wb_active = (state_reg == S_WB) && !wr_en_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg_we
      assign reg_we[gi] = wb_active && (wb_sel == RW'(gi));
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    op1_next     = op1_reg;
    op0_next     = op0_reg;
    result_next  = result_reg;
    wr_en_next   = wr_en_reg;
    retired_next = retired_reg;

    case (state_reg)
      S_IF: begin
        ir_next    = mem_rd_data1;
        pc_next    = pc_reg + N'(1);
        state_next = S_ID;
      end
      S_ID: begin
        op1_next   = regs_reg[reg1];
        op0_next   = mem_src ? mem_rd_data2 : regs_reg[reg0];
        state_next = needs_imm ? S_IMM : S_EX;
      end
      S_IMM: begin
        op0_next   = mem_rd_data1;
        pc_next    = pc_reg + N'(1);
        state_next = S_EX;
      end
      S_EX: begin
        state_next = S_WB;
        wr_en_next = mem_src && !dst;
        case (op)
          OP_ADD, OP_ADDI: result_next = op1_reg + op0_reg;
          OP_SUB, OP_SUBI: result_next = op1_reg - op0_reg;
          OP_MOV:          result_next = dst ? op0_reg : op1_reg;
          OP_MOVI:         result_next = op0_reg;
          default: begin
            // beq / blt retire here and skip WB
            state_next   = S_IF;
            wr_en_next   = 1'b0;
            retired_next = retired_reg + CNT_W'(1);
            if (br_taken) begin
              pc_next = pc_reg + op0_reg;
            end
          end
        endcase
      end
      S_WB: begin
        wr_en_next   = 1'b0;
        retired_next = retired_reg + CNT_W'(1);
        state_next   = S_IF;
      end
      default: begin
        state_next = S_IF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IF;
      pc_reg      <= '0;
      ir_reg      <= '0;
      op1_reg     <= '0;
      op0_reg     <= '0;
      result_reg  <= '0;
      wr_en_reg   <= 1'b0;
      retired_reg <= '0;
    end else if (!stall) begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      op1_reg     <= op1_next;
      op0_reg     <= op0_next;
      result_reg  <= result_next;
      wr_en_reg   <= wr_en_next;
      retired_reg <= retired_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (!stall) begin
      for (int i = 0; i < NREG; i++) begin
        if (reg_we[i]) begin
          regs_reg[i] <= result_reg;
        end
      end
    end
  end

  assign mem_rd_addr1 = pc_reg;
  assign mem_rd_addr2 = regs_reg[0];
  assign mem_wr_addr  = regs_reg[0];
  assign mem_wr_data  = result_reg;
  assign mem_wr_en    = wr_en_reg;
  assign retired      = retired_reg;

endmodule
